morse_key_timer: RTL and testbench
==================================

Name: morse_key_timer

Overview:
- Front end of decode mode. Times presses and gaps on the debounced Morse key and classifies each press as a dot or dash.
- Accumulates up to MAX_SYM symbols per letter. Emits a letter (code + length) once the key has been released for a letter gap.
- Feeds the downstream decoder lookup and display path. Also forwards backspace when the letter buffer is already empty.

Parameters:
- DOT_MAX, 300, press shorter than this many ticks = dot.
- DASH_MAX, 1000, press from DOT_MAX to DASH_MAX ticks inclusive = dash; longer = cancel.
- GAP_LETTER, 800, release ticks (≥ this) that close a letter.
- CNT_W, 11, width of the duration counter; saturates at all-ones.
- MAX_SYM, 5, symbols per letter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- enable  in  1  decode mode active; low = flush to IDLE
- tick  in  1  1 ms strobe, one clk wide
- key_in  in  1  debounced key level, 1 = pressed
- bs_in  in  1  debounced backspace, level
- char_code  out  5  bit i = symbol i (0 dot, 1 dash), first symbol in bit 0
- char_len  out  3  symbols in char_code, 1..5
- char_err  out  1  letter had an overflow, valid with char_valid
- char_valid  out  1  one-cycle strobe
- bs_out  out  1  one-cycle strobe: delete last decoded character downstream
- cur_len  out  3  live symbol count, for LED feedback
- busy  out  1  high in PRESS or GAP

Behaviour:
- Reset: all outputs 0; state IDLE; buffer code = 0, len = 0; counter = 0; key_q = 0; bs_q = 0.
- Edge detection:
  - key_in registered into key_q; rise = key_in & ~key_q, fall = ~key_in & key_q.
  - bs_in registered into bs_q; backspace event = rising edge, one event per press.
- Counter:
  - Cleared on every key edge.
  - Increments on tick; saturates at 2^CNT_W-1.
- State IDLE: on rise, go to PRESS.
- State PRESS: on fall, classify using the counter value before clearing.
  - < DOT_MAX: dot.
  - ≤ DASH_MAX: dash.
  - Otherwise cancel: clear buffer, len = 0, go to IDLE.
  - Append (dot/dash): if len < MAX_SYM, write bit[len] and increment len; if len == MAX_SYM, drop the symbol and set overflow sticky.
  - After append, go to GAP.
- State GAP:
  - Rise: go to PRESS; the letter continues.
  - Counter reaches GAP_LETTER with len > 0: go to EMIT.
  - Counter reaches GAP_LETTER with len == 0: go to IDLE.
- State EMIT (one cycle):
  - Drive char_code, char_len, char_err (= overflow sticky) with char_valid = 1.
  - Clear buffer, len and overflow; go to IDLE.
  - Outputs are registered, so char_valid appears exactly one cycle after the gap threshold is reached.
- Backspace event:
  - In PRESS: ignored.
  - In IDLE or GAP with len > 0: clear bit[len-1], decrement len, clear overflow; stay in state with the counter unchanged.
  - In IDLE with len == 0: bs_out pulses the next cycle.
  - Coincident with the EMIT cycle: emit proceeds and bs_out pulses the following cycle, deleting the just-emitted character.
- enable low: synchronous flush to IDLE; buffer, counter and sticky cleared; no strobes; inputs ignored.
- tick and a key edge in the same cycle: the edge wins, counter cleared to 0.
- Reset mid-press: no symbol recorded; the next press starts fresh after reset.
- cur_len = len.

Decomposition:
- Shared package morse_pkg holds:
  - state encoding (IDLE, PRESS, GAP, EMIT);
  - symbol constants SYM_DOT = 0, SYM_DASH = 1;
  - MAX_SYM, timing defaults.
- One natural sub-module: duration_counter (tick-gated, clear-on-edge, saturating, CNT_W wide). All other logic stays in this block.

Test Plan:
- Press 100 ticks, release, idle 800 ticks -> one char_valid, char_code = 5'b00000, char_len = 1, char_err = 0 (E).
- Press 100, gap 200, press 500, gap 800 -> char_code = 5'b00010, char_len = 2 (A); cur_len steps 1, 2, 0.
- Six 100-tick presses with 200-tick gaps, then gap 800 -> char_len = 5, char_code = 0, char_err = 1.
- Dot, dash, then backspace in GAP, then gap 800 -> char_len = 1, code = 0. Backspace again in IDLE with len = 0 -> bs_out pulse of exactly one cycle.
- Press 1200 ticks after one dot -> buffer cleared, state IDLE, no char_valid after 800-tick gap. Press of exactly 300 -> dash; 299 -> dot; 1000 -> dash.
- Assert rst mid-press at tick 150, release after rst drops -> no symbol, cur_len = 0. enable low during GAP with len = 3 -> no char_valid, cur_len = 0.

Source files
------------

// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse key front end: FSM state encoding, symbol
// values, letter size and timing defaults (all timings are in 1 ms ticks).
// Also provides the press classifier used by morse_key_timer.
// -----------------------------------------------------------------------------
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2,
        ST_EMIT  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CLS_DOT    = 2'd0,
        CLS_DASH   = 2'd1,
        CLS_CANCEL = 2'd2
    } press_cls_e;

    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

    localparam int unsigned MAX_SYM = 5;

    localparam int unsigned DOT_MAX_DEF    = 300;
    localparam int unsigned DASH_MAX_DEF   = 1000;
    localparam int unsigned GAP_LETTER_DEF = 800;
    localparam int          CNT_W_DEF      = 11;

    // Below dot_max is a dot, up to and including dash_max is a dash,
    // anything longer is treated as the operator abandoning the letter.
    function automatic press_cls_e classify_press(input int unsigned dur,
                                                  input int unsigned dot_max,
                                                  input int unsigned dash_max);
        press_cls_e cls;
        if (dur < dot_max) begin
            cls = CLS_DOT;
        end else if (dur <= dash_max) begin
            cls = CLS_DASH;
        end else begin
            cls = CLS_CANCEL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/duration_counter.sv
// -----------------------------------------------------------------------------
// duration_counter
// Tick-gated up-counter used to time key presses and gaps. Clear has priority
// over the tick, so a key edge landing on a tick restarts the count at 0.
// The count saturates at all-ones instead of wrapping.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   clr_i    synchronous clear (key edge or flush)
//   tick_i   1 ms strobe, one clk wide
//   cnt_o    current duration in ticks
// -----------------------------------------------------------------------------
module duration_counter #(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             tick_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/morse_key_timer.sv
// -----------------------------------------------------------------------------
// morse_key_timer
// Decode-mode front end: times presses and gaps on the debounced Morse key,
// classifies each press as dot or dash, collects up to MAX_SYM symbols and
// emits the letter once the key has stayed released for a letter gap.
// Backspace deletes the last buffered symbol, or is forwarded downstream when
// the buffer is already empty.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no letter in progress, waiting for a press
//   PRESS | key held, duration counter timing the press
//   GAP   | key released inside a letter, timing the gap
//   EMIT  | one cycle: letter strobe on the outputs, buffer cleared
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   enable      decode mode active; low flushes to IDLE
//   tick        1 ms strobe
//   key_in      debounced key level, 1 = pressed
//   bs_in       debounced backspace level
//   char_code   symbols of the emitted letter, first symbol in bit 0
//   char_len    number of symbols in char_code
//   char_err    letter overflowed MAX_SYM symbols
//   char_valid  one-cycle letter strobe
//   bs_out      one-cycle strobe: delete last decoded character
//   cur_len     live symbol count
//   busy        high in PRESS or GAP
// -----------------------------------------------------------------------------
module morse_key_timer
    import morse_pkg::*;
#(
    parameter int unsigned DOT_MAX    = DOT_MAX_DEF,
    parameter int unsigned DASH_MAX   = DASH_MAX_DEF,
    parameter int unsigned GAP_LETTER = GAP_LETTER_DEF,
    parameter int          CNT_W      = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       tick,
    input  logic       key_in,
    input  logic       bs_in,
    output logic [4:0] char_code,
    output logic [2:0] char_len,
    output logic       char_err,
    output logic       char_valid,
    output logic       bs_out,
    output logic [2:0] cur_len,
    output logic       busy
);

    state_e     state_q;
    logic       key_q;
    logic       bs_q;
    logic       armed_q;
    logic [4:0] code_q;
    logic [2:0] len_q;
    logic       ovf_q;
    logic [4:0] char_code_q;
    logic [2:0] char_len_q;
    logic       char_err_q;
    logic       char_valid_q;
    logic       bs_out_q;
    logic       busy_q;

    logic             key_rise;
    logic             key_fall;
    logic             press_start;
    logic             bs_ev;
    logic             cnt_clr;
    logic [CNT_W-1:0] cnt;
    logic             gap_done;

    press_cls_e cls;
    logic       sym;
    logic [4:0] code_app_d;
    logic [2:0] len_app_d;
    logic       ovf_app_d;
    logic [4:0] code_del_d;
    logic [2:0] len_del_d;

    assign key_rise = key_in & ~key_q;
    assign key_fall = ~key_in & key_q;
    assign bs_ev    = bs_in & ~bs_q;

    // A key still held when reset or enable is released must not be taken as
    // a fresh press; the key has to be seen low once before a rise counts.
    assign press_start = key_rise & armed_q;

    assign cnt_clr  = ~enable | key_rise | key_fall;
    assign gap_done = (32'(cnt) >= GAP_LETTER);

    duration_counter #(
        .CNT_W (CNT_W)
    ) u_duration_counter (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .tick_i (tick),
        .cnt_o  (cnt)
    );

    // Candidate buffer contents for appending the press just ended and for
    // deleting the newest symbol; the FSM picks which one to commit.
    always_comb begin
        cls        = classify_press(32'(cnt), DOT_MAX, DASH_MAX);
        sym        = (cls == CLS_DASH) ? SYM_DASH : SYM_DOT;
        code_app_d = code_q;
        len_app_d  = len_q;
        ovf_app_d  = ovf_q;
        if (32'(len_q) < MAX_SYM) begin
            code_app_d = code_q | (5'(sym) << len_q);
            len_app_d  = len_q + 3'd1;
        end else begin
            ovf_app_d  = 1'b1;
        end
        code_del_d = code_q & ~(5'b00001 << (len_q - 3'd1));
        len_del_d  = len_q - 3'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            key_q        <= 1'b0;
            bs_q         <= 1'b0;
            armed_q      <= 1'b0;
            code_q       <= '0;
            len_q        <= '0;
            ovf_q        <= 1'b0;
            char_code_q  <= '0;
            char_len_q   <= '0;
            char_err_q   <= 1'b0;
            char_valid_q <= 1'b0;
            bs_out_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            key_q        <= key_in;
            bs_q         <= bs_in;
            armed_q      <= armed_q | ~key_in;
            char_valid_q <= 1'b0;
            bs_out_q     <= 1'b0;

            if (!enable) begin
                state_q     <= ST_IDLE;
                armed_q     <= 1'b0;
                code_q      <= '0;
                len_q       <= '0;
                ovf_q       <= 1'b0;
                char_code_q <= '0;
                char_len_q  <= '0;
                char_err_q  <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (press_start) begin
                            state_q <= ST_PRESS;
                            busy_q  <= 1'b1;
                        end else if (bs_ev) begin
                            if (len_q != 3'd0) begin
                                code_q <= code_del_d;
                                len_q  <= len_del_d;
                                ovf_q  <= 1'b0;
                            end else begin
                                bs_out_q <= 1'b1;
                            end
                        end
                    end

                    ST_PRESS: begin
                        if (key_fall) begin
                            if (cls == CLS_CANCEL) begin
                                state_q <= ST_IDLE;
                                code_q  <= '0;
                                len_q   <= '0;
                                ovf_q   <= 1'b0;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= ST_GAP;
                                code_q  <= code_app_d;
                                len_q   <= len_app_d;
                                ovf_q   <= ovf_app_d;
                            end
                        end
                    end

                    ST_GAP: begin
                        if (press_start) begin
                            state_q <= ST_PRESS;
                        end else if (gap_done) begin
                            busy_q <= 1'b0;
                            if (len_q != 3'd0) begin
                                // Output registers load on entry so the strobe
                                // is visible during the EMIT cycle itself.
                                state_q      <= ST_EMIT;
                                char_code_q  <= code_q;
                                char_len_q   <= len_q;
                                char_err_q   <= ovf_q;
                                char_valid_q <= 1'b1;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else if (bs_ev && (len_q != 3'd0)) begin
                            code_q <= code_del_d;
                            len_q  <= len_del_d;
                            ovf_q  <= 1'b0;
                        end
                    end

                    ST_EMIT: begin
                        code_q      <= '0;
                        len_q       <= '0;
                        ovf_q       <= 1'b0;
                        char_code_q <= '0;
                        char_len_q  <= '0;
                        char_err_q  <= 1'b0;
                        // The letter has already left, so a backspace here
                        // deletes it downstream.
                        if (bs_ev) begin
                            bs_out_q <= 1'b1;
                        end
                        if (press_start) begin
                            state_q <= ST_PRESS;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end

                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign char_code  = char_code_q;
    assign char_len   = char_len_q;
    assign char_err   = char_err_q;
    assign char_valid = char_valid_q;
    assign bs_out     = bs_out_q;
    assign cur_len    = len_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_morse_key_timer.sv
module tb_morse_key_timer;

    localparam int T_DOT_MAX  = 300;
    localparam int T_DASH_MAX = 1000;
    localparam int T_GAP      = 800;
    localparam int T_MAX_SYM  = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       tick;
    logic       key_in;
    logic       bs_in;
    logic [4:0] char_code;
    logic [2:0] char_len;
    logic       char_err;
    logic       char_valid;
    logic       bs_out;
    logic [2:0] cur_len;
    logic       busy;

    always #5 clk = ~clk;

    morse_key_timer dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .tick       (tick),
        .key_in     (key_in),
        .bs_in      (bs_in),
        .char_code  (char_code),
        .char_len   (char_len),
        .char_err   (char_err),
        .char_valid (char_valid),
        .bs_out     (bs_out),
        .cur_len    (cur_len),
        .busy       (busy)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0] code;
        logic [2:0] len;
        logic       err;
    } letter_t;

    // ---------------- monitor ----------------
    int      cyc = 0;
    letter_t obs_q[$];
    int      bs_pulses    = 0;
    int      bs_run       = 0;
    int      bs_width_max = 0;
    int      cv_run       = 0;
    int      cv_width_max = 0;
    int      last_cv_cyc  = -100;
    int      last_bs_cyc  = -100;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (char_valid === 1'b1) begin
            letter_t l;
            l.code = char_code;
            l.len  = char_len;
            l.err  = char_err;
            obs_q.push_back(l);
            last_cv_cyc = cyc;
            cv_run++;
            if (cv_run > cv_width_max) cv_width_max = cv_run;
        end else begin
            cv_run = 0;
        end
        if (bs_out === 1'b1) begin
            if (bs_run == 0) begin
                bs_pulses++;
                last_bs_cyc = cyc;
            end
            bs_run++;
            if (bs_run > bs_width_max) bs_width_max = bs_run;
        end else begin
            bs_run = 0;
        end
    end

    // ---------------- reference model ----------------
    int      m_syms[$];
    bit      m_ovf    = 1'b0;
    bit      m_in_gap = 1'b0;
    int      m_bs     = 0;
    letter_t exp_q[$];

    function automatic int model_code();
        int c = 0;
        foreach (m_syms[i]) c += m_syms[i] * (1 << i);
        return c;
    endfunction

    task automatic model_clear();
        m_syms.delete();
        m_ovf    = 1'b0;
        m_in_gap = 1'b0;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_letters(input string tag);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            letter_t o = obs_q.pop_front();
            letter_t e = exp_q.pop_front();
            chk({tag, "_code"}, o.code, e.code);
            chk({tag, "_len"},  o.len,  e.len);
            chk({tag, "_err"},  o.err,  e.err);
        end
        obs_q.delete();
        exp_q.delete();
        chk({tag, "_cur_len"}, cur_len, m_syms.size());
    endtask

    // ---------------- stimulus primitives ----------------
    task automatic tick_n(input int n);
        repeat (n) begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
        end
    endtask

    task automatic press(input int dur);
        @(negedge clk) key_in = 1'b1;
        @(negedge clk);
        chk("busy_in_press", busy, 1);
        tick_n(dur);
        @(negedge clk) key_in = 1'b0;
        @(negedge clk);
        if (dur > T_DASH_MAX) begin
            model_clear();
        end else begin
            if (m_syms.size() < T_MAX_SYM) m_syms.push_back((dur < T_DOT_MAX) ? 0 : 1);
            else m_ovf = 1'b1;
            m_in_gap = 1'b1;
        end
        chk("cur_len_after_press", cur_len, m_syms.size());
        chk("busy_after_press", busy, m_in_gap);
    endtask

    task automatic gap(input int dur);
        tick_n(dur);
        repeat (3) @(negedge clk);
        if (m_in_gap && dur >= T_GAP) begin
            if (m_syms.size() > 0) begin
                letter_t e;
                e.code = 5'(model_code());
                e.len  = 3'(m_syms.size());
                e.err  = m_ovf;
                exp_q.push_back(e);
            end
            model_clear();
        end
    endtask

    task automatic backspace();
        @(negedge clk) bs_in = 1'b1;
        repeat (2) @(negedge clk);
        bs_in = 1'b0;
        repeat (2) @(negedge clk);
        if (m_syms.size() > 0) begin
            void'(m_syms.pop_back());
            m_ovf = 1'b0;
        end else if (!m_in_gap) begin
            m_bs++;
        end
        chk("bs_cur_len", cur_len, m_syms.size());
        chk("bs_pulse_count", bs_pulses, m_bs);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int n;
        int d;
        rst    = 1'b1;
        enable = 1'b1;
        tick   = 1'b0;
        key_in = 1'b0;
        bs_in  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_char_valid", char_valid, 0);
        chk("rst_char_code",  char_code,  0);
        chk("rst_char_len",   char_len,   0);
        chk("rst_char_err",   char_err,   0);
        chk("rst_bs_out",     bs_out,     0);
        chk("rst_cur_len",    cur_len,    0);
        chk("rst_busy",       busy,       0);

        // E
        press(100); gap(800);
        check_letters("E");

        // A, cur_len steps 1, 2, 0
        press(100); gap(200);
        press(500); gap(800);
        check_letters("A");

        // overflow: six dots
        for (int i = 0; i < 6; i++) begin
            press(100);
            if (i < 5) gap(200);
        end
        gap(800);
        check_letters("OVF");

        // dot, dash, backspace in GAP, then empty-buffer backspace in IDLE
        press(100); gap(200);
        press(500);
        backspace();
        gap(800);
        check_letters("BS_GAP");
        backspace();
        chk("bs_width", bs_width_max, 1);

        // cancel by over-long press
        press(100); gap(200);
        press(1200);
        gap(800);
        check_letters("CANCEL");

        // classification boundaries: 300 dash, 299 dot, 1000 dash
        press(300);  gap(100);
        press(299);  gap(100);
        press(1000); gap(800);
        check_letters("BOUND");

        // reset in the middle of a press
        @(negedge clk) key_in = 1'b1;
        @(negedge clk);
        tick_n(150);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        chk("rst_mid_busy", busy, 0);
        key_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid_cur_len", cur_len, 0);
        gap(850);
        check_letters("RST_MID");

        // enable low during GAP with three symbols
        press(100); gap(100);
        press(100); gap(100);
        press(100);
        chk("en_pre_len", cur_len, 3);
        @(negedge clk) enable = 1'b0;
        repeat (4) @(negedge clk);
        enable = 1'b1;
        model_clear();
        @(negedge clk);
        chk("en_flush_len",  cur_len, 0);
        chk("en_flush_busy", busy,    0);
        gap(850);
        check_letters("EN_FLUSH");

        // backspace coincident with the EMIT cycle
        press(100);
        tick_n(T_GAP);
        @(negedge clk) bs_in = 1'b1;
        repeat (2) @(negedge clk);
        bs_in = 1'b0;
        repeat (3) @(negedge clk);
        begin
            letter_t e;
            e.code = 5'd0; e.len = 3'd1; e.err = 1'b0;
            exp_q.push_back(e);
        end
        model_clear();
        m_bs++;
        check_letters("EMIT_BS");
        chk("emit_bs_count", bs_pulses, m_bs);
        chk("emit_bs_timing", last_bs_cyc - last_cv_cyc, 1);

        // randomized letters
        for (int l = 0; l < 3; l++) begin
            n = $urandom_range(1, 6);
            for (int s = 0; s < n; s++) begin
                if ($urandom_range(0, 1) == 0) d = $urandom_range(20, 150);
                else d = $urandom_range(300, 420);
                press(d);
                if ($urandom_range(0, 3) == 0) backspace();
                if (s < n - 1) gap($urandom_range(20, 120));
            end
            gap($urandom_range(800, 830));
            check_letters("RAND");
        end

        chk("char_valid_width", cv_width_max, 1);
        chk("bs_width_final", bs_width_max, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
